// File: rtl/op_handler_sequencer_if.sv
// op_handler_sequencer_if: opcode handshake, handler control and position signals of the sequencer
interface op_handler_sequencer_if #(
    parameter int CMD_W = 8,
    parameter int POS_W = 16
);
    logic                    op_valid;
    logic [CMD_W-1:0]        op_cmd;
    logic                    op_rdy;
    logic [1:0]              hnd_sel;
    logic [2:0]              hnd_rdy;
    logic [2:0]              hnd_trigger;
    logic [2:0]              hnd_done;
    logic                    pos_update;
    logic signed [POS_W-1:0] new_x;
    logic signed [POS_W-1:0] new_y;
    logic signed [POS_W-1:0] cur_x;
    logic signed [POS_W-1:0] cur_y;
    logic                    op_done;
    logic                    busy;
    logic                    unknown_cmd;
    logic                    timeout_err;
    logic                    clr_err;

    modport master (
        input  op_valid, op_cmd, hnd_rdy, hnd_done, pos_update, new_x, new_y, clr_err,
        output op_rdy, hnd_sel, hnd_trigger, cur_x, cur_y, op_done, busy, unknown_cmd, timeout_err
    );

    modport slave (
        output op_valid, op_cmd, hnd_rdy, hnd_done, pos_update, new_x, new_y, clr_err,
        input  op_rdy, hnd_sel, hnd_trigger, cur_x, cur_y, op_done, busy, unknown_cmd, timeout_err
    );
endinterface

// File: rtl/op_handler_sequencer.sv
// op_handler_sequencer: accepts one opcode at a time, selects and triggers its handler, waits for done with a watchdog, tracks position
module op_handler_sequencer #(
    parameter int               CMD_W          = 8,
    parameter int               POS_W          = 16,
    parameter int               TIMEOUT_CYCLES = 2**20,
    parameter logic [CMD_W-1:0] OP_G00         = CMD_W'(0),
    parameter logic [CMD_W-1:0] OP_G01         = CMD_W'(1),
    parameter logic [CMD_W-1:0] OP_G02         = CMD_W'(2),
    parameter logic [CMD_W-1:0] OP_G03         = CMD_W'(3),
    parameter logic [CMD_W-1:0] OP_G90         = CMD_W'(90),
    parameter logic [CMD_W-1:0] OP_G91         = CMD_W'(91),
    parameter logic [CMD_W-1:0] OP_M05         = CMD_W'(105)
) (
    input logic                  clk,
    input logic                  reset,
    op_handler_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ARM, S_WAIT} state_t;

    localparam int WD_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                  r_state, w_next;
    logic [1:0]              r_sel, w_dec_sel;
    logic                    w_dec_unknown, w_accept, w_fire, w_done, w_timeout;
    logic [2:0]              r_trigger;
    logic [WD_W-1:0]         r_wd, w_wd_inc;
    logic                    r_op_done, r_unknown, r_err;
    logic signed [POS_W-1:0] r_cur_x, r_cur_y;

    assign w_wd_inc = r_wd + WD_W'(1);

    // decode the offered opcode into a handler select; unrecognised codes go to the dummy handler
    always_comb begin
        w_dec_sel     = (bus.op_cmd == OP_G00 || bus.op_cmd == OP_G01) ? 2'd0 :
                        (bus.op_cmd == OP_G02 || bus.op_cmd == OP_G03) ? 2'd1 : 2'd2;
        w_dec_unknown = !(bus.op_cmd == OP_G00 || bus.op_cmd == OP_G01 || bus.op_cmd == OP_G02 ||
                          bus.op_cmd == OP_G03 || bus.op_cmd == OP_M05 || bus.op_cmd == OP_G90 ||
                          bus.op_cmd == OP_G91);
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next state; done is ignored while the trigger pulse is still out, and beats a same-cycle timeout
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_fire    = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.op_valid;
                w_next   = bus.op_valid ? S_SETTLE : S_IDLE;
            end
            S_SETTLE: w_next = S_ARM;
            S_ARM: begin
                w_fire = bus.hnd_rdy[r_sel];
                w_next = bus.hnd_rdy[r_sel] ? S_WAIT : S_ARM;
            end
            S_WAIT: begin
                w_done    = bus.hnd_done[r_sel] && r_trigger == 3'b000;
                w_timeout = !w_done && TIMEOUT_CYCLES != 0 && w_wd_inc == WD_W'(TIMEOUT_CYCLES);
                w_next    = (w_done || w_timeout) ? S_IDLE : S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // handler select, trigger pulse, watchdog, status pulses and sticky timeout error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel     <= 2'd2;
            r_trigger <= 3'b000;
            r_wd      <= '0;
            r_op_done <= 1'b0;
            r_unknown <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sel     <= w_accept ? w_dec_sel : r_sel;
            r_trigger <= w_fire ? 3'b001 << r_sel : 3'b000;
            r_wd      <= w_fire ? '0 : (r_state == S_WAIT ? w_wd_inc : r_wd);
            r_op_done <= w_done;
            r_unknown <= w_accept && w_dec_unknown;
            r_err     <= w_timeout || (r_err && !bus.clr_err);
        end
    end

    // committed position follows the muxed position strobe in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else if (bus.pos_update) begin
            r_cur_x <= bus.new_x;
            r_cur_y <= bus.new_y;
        end
    end

    assign bus.op_rdy      = r_state == S_IDLE;
    assign bus.busy        = r_state != S_IDLE;
    assign bus.hnd_sel     = r_sel;
    assign bus.hnd_trigger = r_trigger;
    assign bus.op_done     = r_op_done;
    assign bus.unknown_cmd = r_unknown;
    assign bus.timeout_err = r_err;
    assign bus.cur_x       = r_cur_x;
    assign bus.cur_y       = r_cur_y;
endmodule

// File: tb/tb_op_handler_sequencer.sv
// tb_op_handler_sequencer: directed checks of accept/settle/arm/wait timing, decode, watchdog, position and reset
module tb_op_handler_sequencer;
    localparam int         TO  = 16;
    localparam logic [7:0] G00 = 8'd0;
    localparam logic [7:0] G01 = 8'd1;
    localparam logic [7:0] G02 = 8'd2;
    localparam logic [7:0] G03 = 8'd3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    op_handler_sequencer_if #(.CMD_W(8), .POS_W(16)) bus ();

    op_handler_sequencer #(.CMD_W(8), .POS_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_op_rdy"}, 32'(bus.op_rdy), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_sel"}, 32'(bus.hnd_sel), 32'd2);
        check({tag, "_trig"}, 32'(bus.hnd_trigger), 32'd0);
        check({tag, "_op_done"}, 32'(bus.op_done), 32'd0);
        check({tag, "_unknown"}, 32'(bus.unknown_cmd), 32'd0);
        check({tag, "_err"}, 32'(bus.timeout_err), 32'd0);
        check({tag, "_cur_x"}, 32'(bus.cur_x), 32'd0);
        check({tag, "_cur_y"}, 32'(bus.cur_y), 32'd0);
    endtask

    // offer cmd for one edge, then scramble op_cmd to show it is only sampled at accept
    task automatic start_op(input logic [7:0] cmd);
        bus.op_valid = 1'b1;
        bus.op_cmd   = cmd;
        tick();
        bus.op_valid = 1'b0;
        bus.op_cmd   = 8'hFF;
    endtask

    initial begin
        bus.op_valid   = 1'b0;
        bus.op_cmd     = 8'h00;
        bus.hnd_rdy    = 3'b000;
        bus.hnd_done   = 3'b000;
        bus.pos_update = 1'b0;
        bus.new_x      = '0;
        bus.new_y      = '0;
        bus.clr_err    = 1'b0;
        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // 1: G01, all handlers ready, done 5 cycles after trigger
        bus.hnd_rdy = 3'b111;
        start_op(G01);
        check("t1_sel", 32'(bus.hnd_sel), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_op_rdy", 32'(bus.op_rdy), 32'd0);
        check("t1_settle_trig", 32'(bus.hnd_trigger), 32'd0);
        tick();
        check("t1_arm_trig", 32'(bus.hnd_trigger), 32'd0);
        tick();
        check("t1_trig", 32'(bus.hnd_trigger), 32'b001);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_wait_trig", 32'(bus.hnd_trigger), 32'd0);
            check("t1_wait_done", 32'(bus.op_done), 32'd0);
        end
        tick();
        bus.hnd_done = 3'b001;
        tick();
        bus.hnd_done = 3'b000;
        check("t1_op_done", 32'(bus.op_done), 32'd1);
        check("t1_done_op_rdy", 32'(bus.op_rdy), 32'd1);
        check("t1_done_busy", 32'(bus.busy), 32'd0);
        check("t1_err", 32'(bus.timeout_err), 32'd0);
        tick();
        check("t1_done_pulse", 32'(bus.op_done), 32'd0);
        check("t1_sel_hold", 32'(bus.hnd_sel), 32'd0);

        // 2: G02 with its handler not ready for 10 cycles; done in the trigger cycle is ignored
        bus.hnd_rdy = 3'b101;
        start_op(G02);
        check("t2_sel", 32'(bus.hnd_sel), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_stall_busy", 32'(bus.busy), 32'd1);
            check("t2_stall_op_rdy", 32'(bus.op_rdy), 32'd0);
            check("t2_stall_trig", 32'(bus.hnd_trigger), 32'd0);
        end
        bus.hnd_rdy = 3'b111;
        tick();
        check("t2_trig", 32'(bus.hnd_trigger), 32'b010);
        bus.hnd_done = 3'b010;
        tick();
        bus.hnd_done = 3'b000;
        check("t2_trig_off", 32'(bus.hnd_trigger), 32'd0);
        check("t2_early_done_ignored", 32'(bus.op_done), 32'd0);
        check("t2_still_busy", 32'(bus.busy), 32'd1);
        bus.hnd_done = 3'b010;
        tick();
        bus.hnd_done = 3'b000;
        check("t2_op_done", 32'(bus.op_done), 32'd1);

        // 3: unknown command goes to the dummy handler
        tick();
        bus.op_valid = 1'b1;
        bus.op_cmd   = 8'hFF;
        tick();
        bus.op_valid = 1'b0;
        check("t3_unknown", 32'(bus.unknown_cmd), 32'd1);
        check("t3_sel", 32'(bus.hnd_sel), 32'd2);
        tick();
        check("t3_unknown_pulse", 32'(bus.unknown_cmd), 32'd0);
        tick();
        check("t3_trig", 32'(bus.hnd_trigger), 32'b100);
        tick();
        bus.hnd_done = 3'b100;
        tick();
        bus.hnd_done = 3'b000;
        check("t3_op_done", 32'(bus.op_done), 32'd1);
        check("t3_err", 32'(bus.timeout_err), 32'd0);

        // 5: position strobe during WAIT, done on a non-selected index ignored
        start_op(G01);
        tick();
        tick();
        check("t5_trig", 32'(bus.hnd_trigger), 32'b001);
        tick();
        bus.pos_update = 1'b1;
        bus.new_x      = -16'sd300;
        bus.new_y      = 16'sd1200;
        bus.hnd_done   = 3'b100;
        tick();
        bus.pos_update = 1'b0;
        bus.hnd_done   = 3'b000;
        check("t5_cur_x", 32'(bus.cur_x), 32'(-300));
        check("t5_cur_y", 32'(bus.cur_y), 32'd1200);
        check("t5_wrong_idx_done", 32'(bus.op_done), 32'd0);
        check("t5_wrong_idx_busy", 32'(bus.busy), 32'd1);
        bus.hnd_done = 3'b001;
        tick();
        bus.hnd_done = 3'b000;
        check("t5_op_done", 32'(bus.op_done), 32'd1);

        // 4: watchdog expires after 16 WAIT cycles; sticky until clr_err
        start_op(G00);
        tick();
        tick();
        check("t4_trig", 32'(bus.hnd_trigger), 32'b001);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            check("t4_no_err_yet", 32'(bus.timeout_err), 32'd0);
            check("t4_waiting", 32'(bus.busy), 32'd1);
        end
        tick();
        check("t4_err", 32'(bus.timeout_err), 32'd1);
        check("t4_op_rdy", 32'(bus.op_rdy), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_no_op_done", 32'(bus.op_done), 32'd0);
        tick();
        check("t4_sticky", 32'(bus.timeout_err), 32'd1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("t4_cleared", 32'(bus.timeout_err), 32'd0);

        // 6: reset during WAIT of G03 (with a coincident position strobe), then a normal G00
        start_op(G03);
        tick();
        tick();
        check("t6_trig", 32'(bus.hnd_trigger), 32'b010);
        tick();
        reset          = 1'b1;
        bus.pos_update = 1'b1;
        bus.new_x      = 16'sd77;
        bus.new_y      = 16'sd88;
        tick();
        check_reset_state("t6_rst");
        bus.pos_update = 1'b0;
        reset          = 1'b0;
        tick();
        start_op(G00);
        check("t6_sel", 32'(bus.hnd_sel), 32'd0);
        tick();
        tick();
        check("t6_post_trig", 32'(bus.hnd_trigger), 32'b001);
        tick();
        bus.hnd_done = 3'b001;
        tick();
        bus.hnd_done = 3'b000;
        check("t6_op_done", 32'(bus.op_done), 32'd1);
        check("t6_err", 32'(bus.timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end
endmodule
